// File: rtl/expansion_arbiter.sv
// Round-robin sequencer for one expansion shift-register chain: merges masked
// requester writes into the output image and runs one engine frame per update.
module expansion_arbiter #(
    parameter int              WIDTH   = 8,
    parameter int              NREQ    = 2,
    parameter logic [WIDTH-1:0] INIT   = '0,
    parameter int              REFRESH = 1000,
    parameter int              TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_mask,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [WIDTH-1:0]      out_image,
    input  logic [WIDTH-1:0]      in_image,
    output logic                  frame_start,
    input  logic                  frame_done,
    output logic [WIDTH-1:0]      in_snapshot,
    output logic                  in_valid,
    output logic                  busy,
    output logic                  error,
    output logic [2:0]            state_dbg
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Handshake: req_ready[i] is a one-cycle strobe; the requester holds
    // valid/mask/data until the clock edge at which it sees req_ready high.

    state_t            state;
    state_t            state_nxt;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     gnt;
    logic [RW-1:0]     ref_cnt;
    logic [TW-1:0]     to_cnt;

    logic              any_req;
    logic [PW-1:0]     win;
    logic [NREQ-1:0]   win_oh;
    logic [PW-1:0]     ptr_nxt;
    logic              ref_hit;
    logic              to_hit;
    logic              sel_valid;
    logic [WIDTH-1:0]  sel_mask;
    logic [WIDTH-1:0]  sel_data;

    assign state_dbg = state;

    // Two-pass search: first from ptr upward, then wrap to the low indices.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        win_oh  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any_req && req_valid[i] && (PW'(i) >= ptr)) begin
                any_req = 1'b1;
                win     = PW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!any_req && req_valid[i]) begin
                any_req = 1'b1;
                win     = PW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            win_oh[i] = (win == PW'(i));
        end
    end

    assign ptr_nxt = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;

    always_comb begin
        sel_valid = 1'b0;
        sel_mask  = '0;
        sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == PW'(i)) begin
                sel_valid = req_valid[i];
                sel_mask  = req_mask[i*WIDTH +: WIDTH];
                sel_data  = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ref_hit = (REFRESH != 0) && (ref_cnt == RW'(REFRESH - 1));
    assign to_hit  = (to_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nxt = S_ACCEPT;
                end else if (ref_hit) begin
                    state_nxt = S_START;
                end
            end
            S_ACCEPT: state_nxt = S_START;
            S_START:  state_nxt = S_WAIT;
            S_WAIT: begin
                if (frame_done) begin
                    state_nxt = S_DONE;
                end else if (to_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Pulse outputs are registered from the next state so they line up
    // exactly with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ptr         <= '0;
            gnt         <= '0;
            ref_cnt     <= '0;
            to_cnt      <= '0;
            req_ready   <= '0;
            out_image   <= INIT;
            in_snapshot <= '0;
            frame_start <= 1'b0;
            in_valid    <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_nxt;
            req_ready   <= '0;
            frame_start <= (state_nxt == S_START);
            in_valid    <= (state_nxt == S_DONE);
            busy        <= (state_nxt != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        gnt       <= win;
                        ptr       <= ptr_nxt;
                        req_ready <= win_oh;
                    end else if (ref_hit) begin
                        ref_cnt <= '0;
                    end else if (REFRESH != 0) begin
                        ref_cnt <= ref_cnt + 1'b1;
                    end
                end
                S_ACCEPT: begin
                    // A requester that withdrew during accept leaves the image alone.
                    if (sel_valid) begin
                        out_image <= (out_image & ~sel_mask) | (sel_data & sel_mask);
                    end
                end
                S_START: begin
                    to_cnt <= '0;
                end
                S_WAIT: begin
                    if (frame_done) begin
                        in_snapshot <= in_image;
                    end else if (to_hit) begin
                        error <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    ref_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/expansion_arbiter.md
# expansion_arbiter

Sequencer and arbiter for one expansion shift-register chain. It shares the chain's output image between several requesters, applying masked bit updates in round-robin order. Each update triggers a shift/load frame on the shift-register engine, and the block publishes the input image captured at the end of that frame. It also forces periodic refresh frames so inputs are sampled even when no requester writes. It sits between the user logic and the expansion shift-register engine.

## Interface
- WIDTH, 8: bits in the expansion chain.
- NREQ, 2: number of requesters (≥1).
- INIT, 0: reset value of the output image, WIDTH bits.
- REFRESH, 1000: idle cycles before a forced refresh frame; 0 disables refresh.
- TIMEOUT, 65535: maximum WAIT cycles before a frame is abandoned; must be ≥1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester write request.
- req_ready  out  NREQ  one-cycle accept strobe.
- req_mask  in  NREQ*WIDTH  bits to change; requester i uses slice [i*WIDTH +: WIDTH].
- req_data  in  NREQ*WIDTH  new values for the masked bits; same slicing as req_mask.
- out_image  out  WIDTH  image driven to the engine's data_out.
- in_image  in  WIDTH  raw input image from the engine's data_in.
- frame_start  out  1  one-cycle pulse that starts one engine frame.
- frame_done  in  1  one-cycle pulse from the engine marking frame completion.
- in_snapshot  out  WIDTH  input image captured at frame completion.
- in_valid  out  1  one-cycle pulse when in_snapshot updates.
- busy  out  1  high whenever the state is not IDLE.
- error  out  1  sticky flag set by a frame timeout.

## Operation
States and transitions:
- **IDLE:** if any req_valid is high, the round-robin winner g is latched and the next state is ACCEPT. Otherwise, if the refresh counter has reached REFRESH-1, the next state is START. Otherwise the refresh counter increments.
- **ACCEPT:** req_ready[g] = req_valid[g], registered as one cycle. If it is high, at the closing edge out_image ← (out_image & ~mask_g) | (data_g & mask_g). If req_valid[g] has dropped, the image is unchanged and the frame still runs. Next state is START.
- **START:** frame_start = 1 for this cycle. Next state is WAIT. The timeout counter clears.
- **WAIT:** when frame_done is sampled high, in_snapshot ← in_image and the next state is DONE. When the timeout counter reaches TIMEOUT-1, error is set and the next state is IDLE with no in_valid pulse.
- **DONE:** in_valid = 1 for this cycle. Next state is IDLE. The refresh counter clears.

Rules:
- **Round-robin:** the search starts at pointer p. After a grant to g, p ← (g+1) mod NREQ.
- **Requester contract:** hold req_valid, req_mask and req_data stable until req_ready is seen.
- **Collisions:** a request wins over refresh expiry in the same cycle.
- frame_done is ignored outside WAIT.
- A requester that keeps req_valid high after its accept is treated as a new request.
- Changing req_mask or req_data while valid and not ready gives undefined image content, but the state machine stays legal.
- **Reset values:** out_image=INIT, in_snapshot=0, req_ready=0, frame_start=0, in_valid=0, busy=0, error=0, p=0, counters=0, state=IDLE.
- **Reset mid-operation:** reset asserted in any state returns to reset values immediately. A pending engine frame_done after reset is ignored.
- error clears only on reset.

## Timing
- **Request path:** request sampled at edge E0 → req_ready high in cycle E0–E1 → out_image updated at E1 → frame_start high in E1–E2.
- **Frame completion:** frame_done sampled at edge Ed → in_snapshot valid after Ed → in_valid high for exactly one cycle after Ed.
- **Minimum spacing:** two accepts are at least 5 cycles apart when the engine returns frame_done in its first WAIT cycle.
- **Refresh:** a forced frame starts REFRESH idle cycles after the last DONE.
- **Outputs:** all outputs are registered; no combinational input-to-output paths.

## Test plan
- **Reset:** INIT=8'hA5, rst_n low → out_image=A5, every pulse output 0, busy=0, error=0.
- **Single write:** req0 mask=0F, data=03 from image 00 → req_ready[0] for one cycle; out_image=03; one frame_start; frame_done with in_image=5A → in_snapshot=5A and one in_valid pulse.
- **Fairness:** both requesters held valid for 4 grants → grant order 0,1,0,1. Final image correct with req1 mask=F0, data=C0 and req0 mask=0F, data=03 → C3.
- **Refresh:** REFRESH=10, no requests → frame_start every 10 idle cycles plus the frame duration; out_image unchanged.
- **Timeout:** TIMEOUT=20, frame_done withheld → error=1 after 20 WAIT cycles, no in_valid, back in IDLE. The next request is still served.
- **Mid-frame reset:** rst_n pulsed low during WAIT → IDLE with reset values. A subsequent stray frame_done produces no in_valid.
